encoder_layer1_scheduler: RTL
=============================

Name: encoder_layer1_scheduler

Overview:
- Sequences one frame through the encoder layer-1 convolution block.
- Per frame: pulses the layer reset, streams the 28x28 input pixels from the image BRAM, waits for the layer done flag, then opens the layer-1 output BRAM for reads.
- Read access is time-shared between two requesters: A is the layer-2 engine and B is host readback. Arbitration is round-robin with a latency-matched data return.

Parameters:
- PIXEL, 28, input image side length.
- KERNEL, 3, convolution kernel side length.
- STRIDE, 1, convolution stride.
- DATA_WIDTH, 20, fixed-point word width (10 integer + 10 fraction bits).
- ADDR_WIDTH, 13, output BRAM address width.
- PIX_ADDR_WIDTH, 10, image BRAM address width.
- BRAM_LATENCY, 2, read latency in cycles of both BRAMs.
- RESET_CYCLES, 2, length of the layer reset pulse.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame.
- busy  out  1  high from frame start until entry to SERVE.
- frame_done  out  1  high while in SERVE.
- layer_reset  out  1  drives the layer's reset.
- layer_enable_read  out  1  drives the layer's enableReadPixel.
- layer_done  in  1  layer done flag; held high until the layer is reset.
- pixel_addr  out  PIX_ADDR_WIDTH  image BRAM address.
- out_addr  out  ADDR_WIDTH  drives the layer's layer1_output_address.
- out_data  in  DATA_WIDTH  the layer's layer1_output_data.
- req_a / req_b  in  1  read request from A / B.
- addr_a / addr_b  in  ADDR_WIDTH  read address from A / B.
- grant_a / grant_b  out  1  request accepted this cycle.
- rdata  out  DATA_WIDTH  shared read-data bus.
- rvalid_a / rvalid_b  out  1  rdata belongs to A / B.
- addr_err  out  1  pulse: the granted address was out of range.

Behaviour:
- Constants:
  - N_IN = PIXEL*PIXEL = 784.
  - OUT_SIZE = (PIXEL-KERNEL)/STRIDE + 1 = 26.
  - N_OUT = OUT_SIZE*OUT_SIZE = 676.
- Reset values:
  - layer_reset = 1.
  - All other outputs = 0.
  - State = IDLE; RR pointer favours A; return pipeline cleared.
- IDLE:
  - layer_reset = 1.
  - On start: go to RST_LAYER; busy = 1 from the next cycle.
- RST_LAYER:
  - Hold layer_reset = 1 for RESET_CYCLES cycles, then go to STREAM.
  - layer_reset = 0 from STREAM onward.
- STREAM:
  - pixel_addr counts 0..N_IN-1, one step per cycle.
  - layer_enable_read is pixel_addr-issue delayed by BRAM_LATENCY cycles. It is high for exactly N_IN consecutive cycles, aligned with pixel data.
  - State length is N_IN+BRAM_LATENCY cycles. pixel_addr holds at N_IN-1 after the last issue.
  - Then go to WAIT_DONE with layer_enable_read = 0.
- WAIT_DONE:
  - Go to SERVE on the first cycle layer_done = 1.
  - No timeout.
- SERVE:
  - frame_done = 1, busy = 0.
  - At most one grant per cycle; grants are combinational from req_x and the registered RR pointer.
  - Both requesting: grant the side not granted last, then flip the pointer. A single requester always wins.
  - out_addr is registered from the granted address. A requester ID plus an error bit enter a (BRAM_LATENCY+1)-stage shift pipeline.
  - The rvalid of the tagged requester asserts exactly BRAM_LATENCY+1 cycles after grant, with rdata = out_data.
  - Address >= N_OUT: still granted, but out_addr is left unchanged. rdata = 0 and addr_err = 1 in the rvalid cycle.
  - Back-to-back grants are allowed every cycle (full throughput).
- start while in RST_LAYER, STREAM or WAIT_DONE: ignored.
- start while in SERVE:
  - Go to RST_LAYER and stop granting the same cycle.
  - Reads already in flight still complete with their rvalid.
- reset mid-operation: returns to IDLE with reset values on the next edge; the in-flight pipeline is discarded.

Decomposition:
- Shared package holds:
  - State encoding localparams: IDLE, RST_LAYER, STREAM, WAIT_DONE, SERVE.
  - Derived constants N_IN, OUT_SIZE, N_OUT.
  - DATA_WIDTH and ADDR_WIDTH defaults, common with the layer blocks.
- One natural sub-module, rr_read_arbiter_2: the SERVE-state grant logic, the RR pointer and the tagged return pipeline.

Test Plan:
- Reset high for 3 cycles, then start at cycle 10:
  - layer_reset high through cycle 12, low at 13.
  - pixel_addr = 0 at 13, 783 at 796.
  - layer_enable_read high cycles 15..798.
- Model layer_done asserting 50 cycles after STREAM ends -> frame_done = 1 and busy = 0 exactly one cycle later.
- In SERVE, req_a and req_b both held for 6 cycles with addr_a = 5, addr_b = 675:
  - Grants alternate starting with A.
  - Each rvalid arrives 3 cycles after its grant carrying the model BRAM word.
  - No bubbles between grants.
- req_b with addr_b = 676 -> grant_b = 1; 3 cycles later rvalid_b = 1, rdata = 0, addr_err = 1.
- start pulsed in SERVE while 2 reads are in flight -> both rvalids still arrive, no further grants, layer_reset reasserts.
- start pulsed mid-STREAM at pixel_addr = 400 -> ignored, count continues to 783.
- reset asserted mid-STREAM -> next cycle state is IDLE, layer_reset = 1, all other outputs 0.

Source files
------------

// File: rtl/encoder_layer1_scheduler_pkg.sv
// Shared constants and state encoding for the encoder layer-1 scheduler and its
// read arbiter; geometry matches the layer-1 convolution block.
package encoder_layer1_scheduler_pkg;

    localparam int PIXEL  = 28;
    localparam int KERNEL = 3;
    localparam int STRIDE = 1;

    localparam int L1_DATA_WIDTH = 20;
    localparam int L1_ADDR_WIDTH = 13;

    localparam int N_IN     = PIXEL * PIXEL;
    localparam int OUT_SIZE = (PIXEL - KERNEL) / STRIDE + 1;
    localparam int N_OUT    = OUT_SIZE * OUT_SIZE;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RST_LAYER = 3'd1,
        STREAM    = 3'd2,
        WAIT_DONE = 3'd3,
        SERVE     = 3'd4
    } state_t;

endpackage

// File: rtl/rr_read_arbiter_2.sv
// Two-requester round-robin read arbiter for the layer-1 output BRAM with a
// tagged return pipeline so read data comes back to the side that asked for it.
module rr_read_arbiter_2
    import encoder_layer1_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH   = L1_DATA_WIDTH,
    parameter int ADDR_WIDTH   = L1_ADDR_WIDTH,
    parameter int BRAM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  req_a,
    input  logic                  req_b,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    output logic                  grant_a,
    output logic                  grant_b,
    output logic [ADDR_WIDTH-1:0] out_addr,
    input  logic [DATA_WIDTH-1:0] out_data,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid_a,
    output logic                  rvalid_b,
    output logic                  addr_err
);

    localparam int DEPTH = BRAM_LATENCY + 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(N_OUT);

    logic                  prefer_b;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic                  grant_any;
    logic                  grant_err;
    logic [DEPTH-1:0]      vld_a_p;
    logic [DEPTH-1:0]      vld_b_p;
    logic [DEPTH-1:0]      err_p;

    // prefer_b remembers which side lost the most recent grant
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (enable) begin
            if (req_a && (!req_b || !prefer_b)) begin
                grant_a = 1'b1;
            end else if (req_b) begin
                grant_b = 1'b1;
            end
        end
    end

    assign grant_addr = grant_a ? addr_a : addr_b;
    assign grant_any  = grant_a || grant_b;
    assign grant_err  = grant_addr >= ADDR_LIMIT;

    always_ff @(posedge clk) begin
        if (reset) begin
            prefer_b <= 1'b0;
            out_addr <= '0;
            vld_a_p  <= '0;
            vld_b_p  <= '0;
            err_p    <= '0;
        end else begin
            if (grant_a) begin
                prefer_b <= 1'b1;
            end else if (grant_b) begin
                prefer_b <= 1'b0;
            end
            if (grant_any && !grant_err) begin
                out_addr <= grant_addr;
            end
            // one stage for the address register, BRAM_LATENCY for the BRAM
            vld_a_p <= {vld_a_p[DEPTH-2:0], grant_a};
            vld_b_p <= {vld_b_p[DEPTH-2:0], grant_b};
            err_p   <= {err_p[DEPTH-2:0], grant_any && grant_err};
        end
    end

    assign rvalid_a = vld_a_p[DEPTH-1];
    assign rvalid_b = vld_b_p[DEPTH-1];
    assign addr_err = err_p[DEPTH-1];
    assign rdata    = ((rvalid_a || rvalid_b) && !addr_err) ? out_data : '0;

endmodule

// File: rtl/encoder_layer1_scheduler.sv
// Frame sequencer for encoder layer 1: resets the layer, streams the input image,
// waits for completion, then serves time-shared reads of the layer output.
module encoder_layer1_scheduler
    import encoder_layer1_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH     = L1_DATA_WIDTH,
    parameter int ADDR_WIDTH     = L1_ADDR_WIDTH,
    parameter int PIX_ADDR_WIDTH = 10,
    parameter int BRAM_LATENCY   = 2,
    parameter int RESET_CYCLES   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      layer_reset,
    output logic                      layer_enable_read,
    input  logic                      layer_done,
    output logic [PIX_ADDR_WIDTH-1:0] pixel_addr,
    output logic [ADDR_WIDTH-1:0]     out_addr,
    input  logic [DATA_WIDTH-1:0]     out_data,
    input  logic                      req_a,
    input  logic                      req_b,
    input  logic [ADDR_WIDTH-1:0]     addr_a,
    input  logic [ADDR_WIDTH-1:0]     addr_b,
    output logic                      grant_a,
    output logic                      grant_b,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic                      rvalid_a,
    output logic                      rvalid_b,
    output logic                      addr_err
);

    localparam int CNT_W = PIX_ADDR_WIDTH + 1;
    localparam int RST_W = $clog2(RESET_CYCLES + 1);
    localparam logic [CNT_W-1:0]          ISSUE_END   = CNT_W'(N_IN);
    localparam logic [CNT_W-1:0]          STREAM_LAST = CNT_W'(N_IN + BRAM_LATENCY - 1);
    localparam logic [PIX_ADDR_WIDTH-1:0] PIX_LAST    = PIX_ADDR_WIDTH'(N_IN - 1);
    localparam logic [RST_W-1:0]          RST_LAST    = RST_W'(RESET_CYCLES - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        stream_cnt;
    logic [RST_W-1:0]        rst_cnt;
    logic [BRAM_LATENCY-1:0] issue_vld_p;
    logic                    issue_vld;
    logic                    serve_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rst_cnt     <= '0;
            stream_cnt  <= '0;
            issue_vld_p <= '0;
        end else begin
            state      <= state_nxt;
            rst_cnt    <= (state == RST_LAYER) ? rst_cnt + 1'b1 : '0;
            stream_cnt <= (state == STREAM) ? stream_cnt + 1'b1 : '0;
            // enable lines up with pixel data leaving the image BRAM
            issue_vld_p[0] <= issue_vld;
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                issue_vld_p[i] <= issue_vld_p[i-1];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start) state_nxt = RST_LAYER;
            RST_LAYER: if (rst_cnt == RST_LAST) state_nxt = STREAM;
            STREAM:    if (stream_cnt == STREAM_LAST) state_nxt = WAIT_DONE;
            WAIT_DONE: if (layer_done) state_nxt = SERVE;
            SERVE:     if (start) state_nxt = RST_LAYER;
            default:   state_nxt = IDLE;
        endcase
    end

    assign issue_vld         = (state == STREAM) && (stream_cnt < ISSUE_END);
    assign layer_reset       = (state == IDLE) || (state == RST_LAYER);
    assign busy              = (state == RST_LAYER) || (state == STREAM) || (state == WAIT_DONE);
    assign frame_done        = (state == SERVE);
    assign layer_enable_read = issue_vld_p[BRAM_LATENCY-1];
    assign pixel_addr        = (state != STREAM)          ? '0 :
                               (stream_cnt < ISSUE_END)   ? stream_cnt[PIX_ADDR_WIDTH-1:0] :
                                                            PIX_LAST;
    // a restart in SERVE cuts off new grants in the same cycle
    assign serve_en          = (state == SERVE) && !start;

    rr_read_arbiter_2 #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .BRAM_LATENCY (BRAM_LATENCY)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .enable   (serve_en),
        .req_a    (req_a),
        .req_b    (req_b),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .grant_a  (grant_a),
        .grant_b  (grant_b),
        .out_addr (out_addr),
        .out_data (out_data),
        .rdata    (rdata),
        .rvalid_a (rvalid_a),
        .rvalid_b (rvalid_b),
        .addr_err (addr_err)
    );

endmodule
